// File: rtl/ternary_pkg.sv
// ternary_pkg: shared ternary types, word constants, arbiter state enum and address conversion
// Trit encoding: 2'b00 = 0, 2'b01 = +1, 2'b10 = -1 (2'b11 is unused and reads as 0).
// Contents: trit_t, TRIT_WIDTH, ADDR_WIDTH, TRIT9_ZERO, TRIT27_ZERO, arb_state_t, trit9_to_int().
package ternary_pkg;
    typedef logic [1:0] trit_t;
    localparam int TRIT_WIDTH = 27;
    localparam int ADDR_WIDTH = 9;
    localparam trit_t TRIT_P = 2'b01;
    localparam trit_t TRIT_N = 2'b10;
    localparam trit_t [8:0] TRIT9_ZERO = '0;
    localparam trit_t [26:0] TRIT27_ZERO = '0;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
    // Balanced-ternary word address to signed integer, trit 0 least significant; no clamping.
    function automatic int trit9_to_int(input trit_t [8:0] t);
        int v;
        v = 0;
        for (int i = 8; i >= 0; i--) v = v * 3 + (t[i] == TRIT_P ? 1 : t[i] == TRIT_N ? -1 : 0);
        return v;
    endfunction
endpackage

// File: rtl/ternary_addr_check.sv
// ternary_addr_check: combinational bounds check of a balanced-ternary word address
// Ports: addr (9-trit address in), in_range (1 when 0 <= addr < DMEM_DEPTH).
module ternary_addr_check import ternary_pkg::*; #(
    parameter int DMEM_DEPTH = 729
) (
    input  trit_t [ADDR_WIDTH-1:0] addr,
    output logic                   in_range
);
    int v;
    always_comb begin
        v = trit9_to_int(addr);
        in_range = v >= 0 && v < DMEM_DEPTH;
    end
endmodule

// File: rtl/ternary_dmem_arbiter.sv
// ternary_dmem_arbiter: two-requester arbiter with lock and bounds check for the ternary data memory port
// Ports: clk, rst (sync, active-high); p0_*/p1_* request side (req, we, lock, addr, wdata in;
// gnt, rvalid, rdata, err out); dmem_* memory side (addr, wdata, we, re out; rdata in);
// lock_timeout (pulse in the last cycle of a forcibly released lock).
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution; otherwise requester 0 has fixed priority.
module ternary_dmem_arbiter import ternary_pkg::*; #(
    parameter int DMEM_DEPTH = 729,
    parameter int LOCK_MAX   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic                   p0_lock,
    input  trit_t [ADDR_WIDTH-1:0] p0_addr,
    input  trit_t [TRIT_WIDTH-1:0] p0_wdata,
    output logic                   p0_gnt,
    output logic                   p0_rvalid,
    output trit_t [TRIT_WIDTH-1:0] p0_rdata,
    output logic                   p0_err,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic                   p1_lock,
    input  trit_t [ADDR_WIDTH-1:0] p1_addr,
    input  trit_t [TRIT_WIDTH-1:0] p1_wdata,
    output logic                   p1_gnt,
    output logic                   p1_rvalid,
    output trit_t [TRIT_WIDTH-1:0] p1_rdata,
    output logic                   p1_err,
    output trit_t [ADDR_WIDTH-1:0] dmem_addr,
    output trit_t [TRIT_WIDTH-1:0] dmem_wdata,
    output logic                   dmem_we,
    output logic                   dmem_re,
    input  trit_t [TRIT_WIDTH-1:0] dmem_rdata,
    output logic                   lock_timeout
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    arb_state_t state;
    logic [CW-1:0] lock_cnt;
    logic prio0, acc, sel, m_we, m_lock, in_range, timeout;
    trit_t [ADDR_WIDTH-1:0] m_addr;
    trit_t [TRIT_WIDTH-1:0] m_wdata;
`ifdef DMEM_ARB_RR_EN
    // rr_ptr names the requester that wins the next IDLE conflict
    logic rr_ptr;
    assign prio0 = !rr_ptr;
`else
    assign prio0 = 1'b1;
`endif
    // Grants are held low during reset so a request present across reset is never accepted early
    always_comb begin
        p0_gnt = !rst && p0_req && (state == OWN0 || (state == IDLE && (!p1_req || prio0)));
        p1_gnt = !rst && p1_req && (state == OWN1 || (state == IDLE && !(p0_req && prio0)));
        acc = p0_gnt || p1_gnt;
        sel = p1_gnt;
        m_addr = sel ? p1_addr : p0_addr;
        m_wdata = sel ? p1_wdata : p0_wdata;
        m_we = sel ? p1_we : p0_we;
        m_lock = sel ? p1_lock : p0_lock;
        timeout = state != IDLE && lock_cnt == CW'(LOCK_MAX - 1);
        lock_timeout = !rst && timeout;
        dmem_we = acc && in_range && m_we;
        dmem_re = acc && in_range && !m_we;
        dmem_addr = acc ? m_addr : TRIT9_ZERO;
        dmem_wdata = acc ? m_wdata : TRIT27_ZERO;
    end
    ternary_addr_check #(.DMEM_DEPTH(DMEM_DEPTH)) u_addr_check (.addr(m_addr), .in_range(in_range));
    // Out-of-range accesses (reads and writes) answer with err and zero data; in-range writes stay silent
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lock_cnt <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;
            p0_rdata <= TRIT27_ZERO;
            p1_rdata <= TRIT27_ZERO;
`ifdef DMEM_ARB_RR_EN
            rr_ptr <= 1'b0;
`endif
        end else begin
            p0_rvalid <= p0_gnt && (!in_range || !m_we);
            p1_rvalid <= p1_gnt && (!in_range || !m_we);
            p0_err <= p0_gnt && !in_range;
            p1_err <= p1_gnt && !in_range;
            p0_rdata <= p0_gnt && !in_range ? TRIT27_ZERO : p0_gnt && !m_we ? dmem_rdata : p0_rdata;
            p1_rdata <= p1_gnt && !in_range ? TRIT27_ZERO : p1_gnt && !m_we ? dmem_rdata : p1_rdata;
`ifdef DMEM_ARB_RR_EN
            if (acc) rr_ptr <= !sel;
`endif
            if (state == IDLE) begin
                if (acc && m_lock) state <= sel ? OWN1 : OWN0;
                lock_cnt <= '0;
            end else if (timeout || (acc && !m_lock)) begin
                state <= IDLE;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end
endmodule
